reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- 32-entry in-order reorder buffer, directly downstream of the middle end.
- Rename/dispatch allocates one entry per cycle, in program order. The returned index travels with the renamed op as its ROB_entry field.
- Up to three completions per cycle (arith, mem, term) mark entries done, using the middle end's ROB_entries_out and complete_*_valid outputs.
- Retires at most one entry per cycle from the head. On retire it publishes the architectural destinations and frees the superseded physical registers.

Parameters:
- ROB_ADDR_W, 5, entry index width; depth = 2**ROB_ADDR_W.
- PR_ADDR_W, 5, physical register index width.
- AR_W, 4, architectural register code width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  rename presents an op.
- alloc_ready  out  1  entry available (not full).
- alloc_idx  out  ROB_ADDR_W  index the op receives (current tail); valid whenever alloc_ready.
- alloc_arch_dest  in  2*AR_W  [AR_W-1:0]=data dest, upper=flag dest.
- alloc_new_phys  in  2*PR_ADDR_W  newly mapped physical registers.
- alloc_old_phys  in  2*PR_ADDR_W  previous mappings, freed at retire.
- alloc_dest_en  in  2  per-slot destination present.
- complete_rob_entries  in  3*ROB_ADDR_W  [4:0]=term, [9:5]=mem, [14:10]=arith.
- complete_arith_valid  in  1  arith completion valid.
- complete_mem_valid  in  1  mem completion valid.
- complete_term_valid  in  1  term completion valid.
- commit_valid  out  1  head retires this cycle.
- commit_idx  out  ROB_ADDR_W  retiring index.
- commit_arch_dest  out  2*AR_W  arch dests of retiring op.
- commit_new_phys  out  2*PR_ADDR_W  phys regs for retirement map.
- free_phys  out  2*PR_ADDR_W  regs returned to free list.
- free_en  out  2  = alloc_dest_en of retiring op, gated by commit_valid.
- empty  out  1  no live entries.
- err_sticky  out  1  set on completion to a non-live entry; cleared only by rst.

Behaviour:
- State:
  - head_ptr and tail_ptr are ROB_ADDR_W+1 bits; the MSB is the wrap bit.
  - Per-entry valid and done bits, plus a payload RAM.
  - full = (low bits equal) and (wrap bits differ). empty = (pointers equal).
- Reset (synchronous, active-high):
  - head = tail = 0; all valid and done bits = 0; err_sticky = 0.
  - Outputs after reset: alloc_ready=1, alloc_idx=0, commit_valid=0, free_en=0, empty=1.
  - Payload is not reset.
  - Reset mid-operation discards all entries, including completions presented in the same cycle.
- Allocation:
  - Fires when alloc_valid && alloc_ready.
  - Writes the payload at tail, sets valid, clears done, increments tail.
  - alloc_valid while full is ignored; no state change.
- Completion:
  - Each valid port sets done[idx] at the clock edge, if valid[idx] is already set.
  - If valid[idx]=0, done is untouched and err_sticky is set.
  - Several ports may target distinct entries in the same cycle; all take effect.
  - Duplicate indices in the same cycle are legal: done is set once.
- Commit:
  - Combinational from registered state: commit_valid = valid[head] && done[head].
  - On commit, valid[head] and done[head] are cleared and head increments.
  - Earliest commit is the cycle after the completion edge.
  - One retire per cycle, strictly in order. A done entry behind an undone head waits.
- Simultaneous allocate + commit:
  - Both occur; count is unchanged.
  - When full, the alloc is still refused that cycle even if a commit frees a slot. alloc_ready depends on registered state only.
- Freed slot reuse:
  - A completion naming the slot being retired in that cycle sees valid=1 and is harmless.
  - Clearing takes priority over setting done.
- Wrap-around: pointers wrap modulo 2*depth. Indices wrap 31 -> 0 with no special handling.

Test Plan:
- Reset -> alloc_ready=1, alloc_idx=0, empty=1, commit_valid=0, err_sticky=0.
- Allocate idx 0,1,2; complete 2, then 1 (arith), then 0 (term) -> no commit until the cycle after 0 completes. Then commit_idx 0,1,2 on consecutive cycles with matching free_phys/free_en.
- Allocate 32 entries -> alloc_ready=0, alloc_idx=0. Further alloc_valid leaves the tail unchanged.
- Full buffer with head done: assert alloc_valid in the commit cycle -> commit occurs, alloc refused. Alloc accepted the next cycle as idx 0 of the new wrap.
- Same-cycle completion on all three ports to idx 4,5,6 (head=4) -> commits 4,5,6 on three consecutive cycles.
- Completion to an unallocated idx 9 -> err_sticky=1 and entry 9 unaffected. rst mid-run with 10 live entries -> empty=1 next cycle.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: allocation from rename, completions from the middle end,
// and the retire/free outputs toward the architectural map and free list.
//   master : rename/middle-end side (drives alloc_* and complete_*)
//   slave  : reorder buffer side (drives alloc_ready/idx, commit_*, free_*, status)
interface reorder_buffer_if #(
  parameter int ROB_ADDR_W = 5,
  parameter int PR_ADDR_W  = 5,
  parameter int AR_W       = 4
);
  logic                      alloc_valid;
  logic                      alloc_ready;
  logic [ROB_ADDR_W-1:0]     alloc_idx;
  logic [2*AR_W-1:0]         alloc_arch_dest;
  logic [2*PR_ADDR_W-1:0]    alloc_new_phys;
  logic [2*PR_ADDR_W-1:0]    alloc_old_phys;
  logic [1:0]                alloc_dest_en;
  logic [3*ROB_ADDR_W-1:0]   complete_rob_entries;
  logic                      complete_arith_valid;
  logic                      complete_mem_valid;
  logic                      complete_term_valid;
  logic                      commit_valid;
  logic [ROB_ADDR_W-1:0]     commit_idx;
  logic [2*AR_W-1:0]         commit_arch_dest;
  logic [2*PR_ADDR_W-1:0]    commit_new_phys;
  logic [2*PR_ADDR_W-1:0]    free_phys;
  logic [1:0]                free_en;
  logic                      empty;
  logic                      err_sticky;

  modport master (
    output alloc_valid, alloc_arch_dest, alloc_new_phys, alloc_old_phys, alloc_dest_en,
           complete_rob_entries, complete_arith_valid, complete_mem_valid, complete_term_valid,
    input  alloc_ready, alloc_idx, commit_valid, commit_idx, commit_arch_dest,
           commit_new_phys, free_phys, free_en, empty, err_sticky
  );

  modport slave (
    input  alloc_valid, alloc_arch_dest, alloc_new_phys, alloc_old_phys, alloc_dest_en,
           complete_rob_entries, complete_arith_valid, complete_mem_valid, complete_term_valid,
    output alloc_ready, alloc_idx, commit_valid, commit_idx, commit_arch_dest,
           commit_new_phys, free_phys, free_en, empty, err_sticky
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order reorder buffer. One allocation per cycle at the tail, up to three
// completions per cycle (arith/mem/term), one retirement per cycle at the head.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   reorder_buffer_if.slave (alloc, completion, commit/free, status)
module reorder_buffer #(
  parameter int ROB_ADDR_W = 5,
  parameter int PR_ADDR_W  = 5,
  parameter int AR_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  reorder_buffer_if.slave    bus
);
  localparam int DEPTH = 2**ROB_ADDR_W;
  localparam int PTR_W = ROB_ADDR_W + 1;

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
  logic              err_q, err_d;

  // Payload RAM (not reset).
  logic [2*AR_W-1:0]      arch_q    [DEPTH];
  logic [2*PR_ADDR_W-1:0] new_phys_q[DEPTH];
  logic [2*PR_ADDR_W-1:0] old_phys_q[DEPTH];
  logic [1:0]             dest_en_q [DEPTH];

  logic [ROB_ADDR_W-1:0] head_idx, tail_idx;
  logic                  full, empty, alloc_fire, commit_fire;
  logic [2:0][ROB_ADDR_W-1:0] cmp_idx;
  logic [2:0]                 cmp_v;

  assign head_idx    = head_q[ROB_ADDR_W-1:0];
  assign tail_idx    = tail_q[ROB_ADDR_W-1:0];
  assign empty       = (head_q == tail_q);
  assign full        = (head_idx == tail_idx) && (head_q[ROB_ADDR_W] != tail_q[ROB_ADDR_W]);
  // Refusal while full holds even if the head retires this cycle: ready is
  // purely a function of registered pointers.
  assign alloc_fire  = bus.alloc_valid && !full;
  assign commit_fire = valid_q[head_idx] && done_q[head_idx];

  // Port order in the packed vector: [0]=term, [1]=mem, [2]=arith.
  assign cmp_idx = bus.complete_rob_entries;
  assign cmp_v   = {bus.complete_arith_valid, bus.complete_mem_valid, bus.complete_term_valid};

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = err_q;
    head_d  = head_q;
    tail_d  = tail_q;
    // Completions check the registered valid; duplicates simply set done twice.
    for (int p = 0; p < 3; p++) begin
      if (cmp_v[p]) begin
        if (valid_q[cmp_idx[p]]) done_d[cmp_idx[p]] = 1'b1;
        else                     err_d = 1'b1;
      end
    end
    // Retire clears after completion so a late completion to the retiring
    // slot cannot resurrect its done bit.
    if (commit_fire) begin
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
      head_d            = head_q + PTR_W'(1);
    end
    // Tail never aliases a retiring head: that would need full, which blocks alloc.
    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      tail_d            = tail_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      arch_q[tail_idx]     <= bus.alloc_arch_dest;
      new_phys_q[tail_idx] <= bus.alloc_new_phys;
      old_phys_q[tail_idx] <= bus.alloc_old_phys;
      dest_en_q[tail_idx]  <= bus.alloc_dest_en;
    end
  end

  assign bus.alloc_ready      = !full;
  assign bus.alloc_idx        = tail_idx;
  assign bus.commit_valid     = commit_fire;
  assign bus.commit_idx       = head_idx;
  assign bus.commit_arch_dest = arch_q[head_idx];
  assign bus.commit_new_phys  = new_phys_q[head_idx];
  assign bus.free_phys        = old_phys_q[head_idx];
  assign bus.free_en          = dest_en_q[head_idx] & {2{commit_fire}};
  assign bus.empty            = empty;
  assign bus.err_sticky       = err_q;
endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_ADDR_W(5), .PR_ADDR_W(5), .AR_W(4)) bus ();
  reorder_buffer #(.ROB_ADDR_W(5), .PR_ADDR_W(5), .AR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Advance past one rising edge; inputs driven and outputs sampled 1ns later.
  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic set_cmp(input logic [4:0] a, input logic [4:0] m, input logic [4:0] t,
                         input logic va, input logic vm, input logic vt);
    bus.complete_rob_entries = {a, m, t};
    bus.complete_arith_valid = va;
    bus.complete_mem_valid   = vm;
    bus.complete_term_valid  = vt;
  endtask

  task automatic do_alloc(input logic [7:0] ad, input logic [9:0] np, input logic [9:0] op,
                          input logic [1:0] en);
    bus.alloc_arch_dest = ad;
    bus.alloc_new_phys  = np;
    bus.alloc_old_phys  = op;
    bus.alloc_dest_en   = en;
    bus.alloc_valid     = 1'b1;
    step();
    bus.alloc_valid     = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.alloc_ready); end
    checks++; if (bus.alloc_idx !== 5'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", bus.alloc_idx); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit got %b exp 0", bus.commit_valid); end
    checks++; if (bus.err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err_sticky); end
    checks++; if (bus.free_en !== 2'b00) begin errors++; $display("FAIL reset_free_en got %b exp 00", bus.free_en); end
  endtask

  task automatic test_in_order;
    logic [7:0] ad [3];
    logic [9:0] np [3];
    logic [9:0] op [3];
    logic [1:0] en [3];
    ad[0] = 8'h21; np[0] = {5'd11, 5'd10}; op[0] = {5'd4, 5'd3}; en[0] = 2'b11;
    ad[1] = 8'h43; np[1] = {5'd13, 5'd12}; op[1] = {5'd6, 5'd5}; en[1] = 2'b01;
    ad[2] = 8'h65; np[2] = {5'd15, 5'd14}; op[2] = {5'd8, 5'd7}; en[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.alloc_idx !== 5'(i)) begin errors++; $display("FAIL order_alloc_idx got %0d exp %0d", bus.alloc_idx, i); end
      do_alloc(ad[i], np[i], op[i], en[i]);
    end
    set_cmp(5'd0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0); step();
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL order_wait2 got %b exp 0", bus.commit_valid); end
    set_cmp(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); step();
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL order_wait1 got %b exp 0", bus.commit_valid); end
    set_cmp(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); step();
    // Stray completion to the retiring head during its commit edge: harmless.
    set_cmp(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.commit_valid !== 1'b1) begin errors++; $display("FAIL order_cv%0d got %b exp 1", i, bus.commit_valid); end
      checks++; if (bus.commit_idx !== 5'(i)) begin errors++; $display("FAIL order_cidx got %0d exp %0d", bus.commit_idx, i); end
      checks++; if (bus.commit_arch_dest !== ad[i]) begin errors++; $display("FAIL order_arch%0d got %h exp %h", i, bus.commit_arch_dest, ad[i]); end
      checks++; if (bus.commit_new_phys !== np[i]) begin errors++; $display("FAIL order_newp%0d got %h exp %h", i, bus.commit_new_phys, np[i]); end
      checks++; if (bus.free_phys !== op[i]) begin errors++; $display("FAIL order_free%0d got %h exp %h", i, bus.free_phys, op[i]); end
      checks++; if (bus.free_en !== en[i]) begin errors++; $display("FAIL order_free_en%0d got %b exp %b", i, bus.free_en, en[i]); end
      step();
      set_cmp(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL order_empty got %b exp 1", bus.empty); end
    checks++; if (bus.err_sticky !== 1'b0) begin errors++; $display("FAIL order_err got %b exp 0", bus.err_sticky); end
    checks++; if (bus.free_en !== 2'b00) begin errors++; $display("FAIL order_free_idle got %b exp 00", bus.free_en); end
  endtask

  task automatic test_full;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      checks++; if (bus.alloc_idx !== 5'(i)) begin errors++; $display("FAIL full_idx got %0d exp %0d", bus.alloc_idx, i); end
      do_alloc(8'(i), 10'(i), 10'(i + 1), 2'b01);
    end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.alloc_ready); end
    checks++; if (bus.alloc_idx !== 5'd0) begin errors++; $display("FAIL full_idx_wrap got %0d exp 0", bus.alloc_idx); end
    bus.alloc_valid = 1'b1; step(); step(); bus.alloc_valid = 1'b0;
    checks++; if (bus.alloc_idx !== 5'd0) begin errors++; $display("FAIL full_ignore_idx got %0d exp 0", bus.alloc_idx); end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ignore_ready got %b exp 0", bus.alloc_ready); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL full_empty got %b exp 0", bus.empty); end
  endtask

  task automatic test_full_commit;
    set_cmp(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); step(); set_cmp(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.commit_valid !== 1'b1) begin errors++; $display("FAIL fc_cv got %b exp 1", bus.commit_valid); end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL fc_ready got %b exp 0", bus.alloc_ready); end
    bus.alloc_valid = 1'b1; step();
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL fc_cv_after got %b exp 0", bus.commit_valid); end
    checks++; if (bus.commit_idx !== 5'd1) begin errors++; $display("FAIL fc_head got %0d exp 1", bus.commit_idx); end
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL fc_refused_ready got %b exp 1", bus.alloc_ready); end
    checks++; if (bus.alloc_idx !== 5'd0) begin errors++; $display("FAIL fc_refused_idx got %0d exp 0", bus.alloc_idx); end
    step(); bus.alloc_valid = 1'b0;
    checks++; if (bus.alloc_idx !== 5'd1) begin errors++; $display("FAIL fc_accept_idx got %0d exp 1", bus.alloc_idx); end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL fc_accept_ready got %b exp 0", bus.alloc_ready); end
  endtask

  task automatic test_three_ports;
    do_reset();
    for (int i = 0; i < 7; i++) do_alloc(8'(i), 10'(i), 10'(i + 16), 2'b11);
    set_cmp(5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1); step();
    set_cmp(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.commit_valid !== 1'b1 || bus.commit_idx !== 5'(i)) begin errors++; $display("FAIL tp_pre got v=%b idx=%0d exp v=1 idx=%0d", bus.commit_valid, bus.commit_idx, i); end
      step(); set_cmp(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    end
    checks++; if (bus.commit_valid !== 1'b0 || bus.commit_idx !== 5'd4) begin errors++; $display("FAIL tp_head4 got v=%b idx=%0d exp v=0 idx=4", bus.commit_valid, bus.commit_idx); end
    set_cmp(5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1); step(); set_cmp(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 4; i < 7; i++) begin
      checks++; if (bus.commit_valid !== 1'b1 || bus.commit_idx !== 5'(i)) begin errors++; $display("FAIL tp_commit got v=%b idx=%0d exp v=1 idx=%0d", bus.commit_valid, bus.commit_idx, i); end
      checks++; if (bus.free_phys !== 10'(i + 16)) begin errors++; $display("FAIL tp_free got %0d exp %0d", bus.free_phys, i + 16); end
      step();
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL tp_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_error;
    set_cmp(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); step(); set_cmp(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.err_sticky !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", bus.err_sticky); end
    for (int i = 7; i < 10; i++) do_alloc(8'(i), 10'(i), 10'(i), 2'b01);
    set_cmp(5'd7, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0); step(); set_cmp(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.commit_idx !== 5'd7 || bus.commit_valid !== 1'b1) begin errors++; $display("FAIL err_c7 got v=%b idx=%0d exp v=1 idx=7", bus.commit_valid, bus.commit_idx); end
    step(); step();
    checks++; if (bus.commit_idx !== 5'd9 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL err_e9 got v=%b idx=%0d exp v=0 idx=9", bus.commit_valid, bus.commit_idx); end
    // Duplicate completion to the same index in one cycle.
    set_cmp(5'd9, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0); step(); set_cmp(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_idx !== 5'd9) begin errors++; $display("FAIL err_dup got v=%b idx=%0d exp v=1 idx=9", bus.commit_valid, bus.commit_idx); end
    step();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL err_empty got %b exp 1", bus.empty); end
    checks++; if (bus.err_sticky !== 1'b1) begin errors++; $display("FAIL err_hold got %b exp 1", bus.err_sticky); end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 10; i++) do_alloc(8'(i), 10'(i), 10'(i), 2'b11);
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL mr_live got %b exp 0", bus.empty); end
    rst = 1'b1; set_cmp(5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1); step();
    rst = 1'b0; set_cmp(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mr_empty got %b exp 1", bus.empty); end
    checks++; if (bus.err_sticky !== 1'b0) begin errors++; $display("FAIL mr_err got %b exp 0", bus.err_sticky); end
    checks++; if (bus.alloc_idx !== 5'd0) begin errors++; $display("FAIL mr_idx got %0d exp 0", bus.alloc_idx); end
    step();
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL mr_commit got %b exp 0", bus.commit_valid); end
  endtask

  initial begin
    rst = 1'b0;
    bus.alloc_valid = 1'b0; bus.alloc_arch_dest = '0; bus.alloc_new_phys = '0;
    bus.alloc_old_phys = '0; bus.alloc_dest_en = '0;
    set_cmp(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    test_reset();
    test_in_order();
    test_full();
    test_full_commit();
    test_three_ports();
    test_error();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
